seq_shift_unit: RTL and testbench



---
 rtl/seq_shift_if.sv | 37 +++
 rtl/seq_shift_unit.sv | 123 ++++++++++++
 tb/tb_seq_shift_unit.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/seq_shift_if.sv
// Request/result handshake bundle for seq_shift_unit.
// SHIFT_FLAGS_EN adds the carry_out/zero/ovf result flags.
interface seq_shift_if #(
  parameter int WIDTH   = 8,
  parameter int SHAMT_W = 3
);
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   din;
  logic [2:0]         mode;
  logic [SHAMT_W-1:0] shamt;
  logic               out_valid;
  logic               out_ready;
  logic [WIDTH-1:0]   dout;
  logic               busy;
`ifdef SHIFT_FLAGS_EN
  logic               carry_out;
  logic               zero;
  logic               ovf;
`endif

  modport master (
    output in_valid, din, mode, shamt, out_ready,
`ifdef SHIFT_FLAGS_EN
    input  carry_out, zero, ovf,
`endif
    input  in_ready, out_valid, dout, busy
  );

  modport slave (
    input  in_valid, din, mode, shamt, out_ready,
`ifdef SHIFT_FLAGS_EN
    output carry_out, zero, ovf,
`endif
    output in_ready, out_valid, dout, busy
  );
endinterface

// File: rtl/seq_shift_unit.sv
// Multi-cycle shift/rotate engine: one single-bit step per clock, valid/ready in and out.
// Optional macro SHIFT_FLAGS_EN adds registered carry_out/zero/ovf result flags.
module seq_shift_unit #(
  parameter int WIDTH   = 8,
  parameter int SHAMT_W = 3
) (
  input  logic    clk,
  input  logic    rst_,
  seq_shift_if.slave io
);
  localparam logic [2:0] M_LSR = 3'b000, M_LSL = 3'b001, M_ASR = 3'b010,
                         M_ASL = 3'b011, M_ROR = 3'b100, M_ROL = 3'b101;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t             state;
  logic [WIDTH-1:0]   work, nxt;
  logic [2:0]         md;
  logic [SHAMT_W-1:0] cnt;
  logic               in_rdy, out_vld, bsy;

  // Single step of the latched operation applied to the working register.
  always_comb begin
    nxt = work;
    case (md)
      M_LSR:        nxt = {1'b0, work[WIDTH-1:1]};
      M_LSL, M_ASL: nxt = {work[WIDTH-2:0], 1'b0};
      M_ASR:        nxt = {work[WIDTH-1], work[WIDTH-1:1]};
      M_ROR:        nxt = {work[0], work[WIDTH-1:1]};
      M_ROL:        nxt = {work[WIDTH-2:0], work[WIDTH-1]};
      default:      nxt = work;
    endcase
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state   <= IDLE;
      work    <= '0;
      md      <= '0;
      cnt     <= '0;
      in_rdy  <= 1'b1;
      out_vld <= 1'b0;
      bsy     <= 1'b0;
    end else begin
      case (state)
        IDLE: if (io.in_valid) begin
          work   <= io.din;
          md     <= io.mode;
          cnt    <= io.shamt;
          in_rdy <= 1'b0;
          bsy    <= 1'b1;
          // Zero shifts and pass-through modes skip straight to the result.
          if (io.shamt != '0 && !(io.mode[2] && io.mode[1])) begin
            state <= SHIFT;
          end else begin
            state   <= DONE;
            out_vld <= 1'b1;
          end
        end
        SHIFT: begin
          work <= nxt;
          cnt  <= cnt - SHAMT_W'(1);
          if (cnt == SHAMT_W'(1)) begin
            state   <= DONE;
            out_vld <= 1'b1;
          end
        end
        DONE: if (io.out_ready) begin
          state   <= IDLE;
          out_vld <= 1'b0;
          in_rdy  <= 1'b1;
          bsy     <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign io.in_ready  = in_rdy;
  assign io.out_valid = out_vld;
  assign io.busy      = bsy;
  assign io.dout      = work;

`ifdef SHIFT_FLAGS_EN
  logic cout, f_carry, f_zero, f_ovf;

  // Bit leaving the register this step; for rotates it is the bit that wraps.
  always_comb begin
    cout = 1'b0;
    case (md)
      M_LSR, M_ASR, M_ROR:        cout = work[0];
      M_LSL, M_ASL, M_ROL:        cout = work[WIDTH-1];
      default:                    cout = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      f_carry <= 1'b0;
      f_zero  <= 1'b0;
      f_ovf   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (io.in_valid) begin
          f_carry <= 1'b0;
          f_ovf   <= 1'b0;
          f_zero  <= (io.din == '0);
        end
        SHIFT: begin
          f_carry <= cout;
          if (md == M_ASL && nxt[WIDTH-1] != work[WIDTH-1]) f_ovf <= 1'b1;
          f_zero <= (nxt == '0);
        end
        default: ;
      endcase
    end
  end

  assign io.carry_out = f_carry;
  assign io.zero      = f_zero;
  assign io.ovf       = f_ovf;
`endif
endmodule

// File: tb/tb_seq_shift_unit.sv
// Self-checking bench for seq_shift_unit: directed table, corner sequences, random vs model.
module tb_seq_shift_unit;
  localparam int W = 8;
  localparam int SW = 3;

  logic clk = 1'b0;
  logic rst_ = 1'b0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  seq_shift_if #(.WIDTH(W), .SHAMT_W(SW)) bus();
  seq_shift_unit #(.WIDTH(W), .SHAMT_W(SW)) dut (.clk(clk), .rst_(rst_), .io(bus));

  typedef struct {
    logic [2:0]    mode;
    logic [W-1:0]  din;
    logic [SW-1:0] shamt;
    logic [W-1:0]  exp;
    int            lat;
  } vec_t;

  vec_t tbl[9];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // Reference: closed-form shift/rotate arithmetic rather than step-by-step iteration.
  function automatic logic [W-1:0] model(input logic [2:0] m, input logic [W-1:0] d, input int s);
    logic [2*W-1:0] dd, rl;
    int r;
    r  = s % W;
    dd = {d, d};
    rl = dd << r;
    case (m)
      3'd0:       return d >> s;
      3'd1, 3'd3: return d << s;
      3'd2:       return W'($signed(d) >>> s);
      3'd4:       return W'(dd >> r);
      3'd5:       return rl[2*W-1:W];
      default:    return d;
    endcase
  endfunction

  function automatic logic model_carry(input logic [2:0] m, input logic [W-1:0] d, input int s);
    logic [W-1:0] res;
    res = model(m, d, s);
    if (s == 0 || m >= 3'd6) return 1'b0;
    case (m)
      3'd0:       return (s <= W) ? d[s-1] : 1'b0;
      3'd2:       return (s < W) ? d[s-1] : d[W-1];
      3'd1, 3'd3: return (s <= W) ? d[W-s] : 1'b0;
      3'd4:       return res[W-1];
      default:    return res[0];
    endcase
  endfunction

  // ASL overflow: MSB takes values d[W-1], d[W-2], ... across the steps.
  function automatic logic model_ovf(input logic [2:0] m, input logic [W-1:0] d, input int s);
    logic o;
    o = 1'b0;
    if (m != 3'd3) return 1'b0;
    for (int j = 1; j <= s; j++)
      if (((W-1-j >= 0) ? d[W-1-j] : 1'b0) != d[W-1]) o = 1'b1;
    return o;
  endfunction

  task automatic run(input string nm, input logic [2:0] m, input logic [W-1:0] d,
                     input logic [SW-1:0] s, input logic [W-1:0] e, input int el,
                     input bit noise);
    int n;
    @(negedge clk);
    n = 0;
    while (!bus.in_ready && n < 50) begin @(negedge clk); n++; end
    chk({nm, "_ready"}, bus.in_ready, 1);
    bus.in_valid = 1'b1; bus.din = d; bus.mode = m; bus.shamt = s; bus.out_ready = 1'b0;
    @(posedge clk); #1;
    // Inputs after the acceptance edge must have no effect.
    bus.in_valid = noise; bus.din = W'($urandom); bus.mode = 3'($urandom); bus.shamt = SW'($urandom);
    n = 0;
    while (!bus.out_valid && n < 50) begin
      @(posedge clk); #1; n++;
      if (noise) bus.in_valid = 1'($urandom);
    end
    chk({nm, "_lat"}, n, el);
    chk({nm, "_dout"}, bus.dout, e);
    chk({nm, "_busy"}, bus.busy, 1);
    chk({nm, "_inrdy_low"}, bus.in_ready, 0);
`ifdef SHIFT_FLAGS_EN
    chk({nm, "_carry"}, bus.carry_out, model_carry(m, d, int'(s)));
    chk({nm, "_zero"}, bus.zero, (e == '0));
    chk({nm, "_ovf"}, bus.ovf, model_ovf(m, d, int'(s)));
`endif
    @(negedge clk);
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    @(posedge clk); #1;
    chk({nm, "_ov_clr"}, bus.out_valid, 0);
    chk({nm, "_idle_rdy"}, bus.in_ready, 1);
    chk({nm, "_idle_busy"}, bus.busy, 0);
    chk({nm, "_keep"}, bus.dout, e);
    bus.out_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{3'd0, 8'hB4, 3'd3, 8'h16, 3};
    tbl[1] = '{3'd2, 8'h90, 3'd2, 8'hE4, 2};
    tbl[2] = '{3'd2, 8'h80, 3'd7, 8'hFF, 7};
    tbl[3] = '{3'd0, 8'hFF, 3'd7, 8'h01, 7};
    tbl[4] = '{3'd5, 8'h81, 3'd1, 8'h03, 1};
    tbl[5] = '{3'd4, 8'h81, 3'd5, 8'h0C, 5};
    tbl[6] = '{3'd1, 8'h5A, 3'd0, 8'h5A, 0};
    tbl[7] = '{3'd6, 8'h3C, 3'd5, 8'h3C, 0};
    tbl[8] = '{3'd3, 8'h80, 3'd1, 8'h00, 1};

    bus.in_valid = 1'b0; bus.din = '0; bus.mode = '0; bus.shamt = '0; bus.out_ready = 1'b0;
    #23;
    chk("rst_dout", bus.dout, 0);
    chk("rst_ov", bus.out_valid, 0);
    chk("rst_inrdy", bus.in_ready, 1);
    chk("rst_busy", bus.busy, 0);
`ifdef SHIFT_FLAGS_EN
    chk("rst_flags", {bus.carry_out, bus.zero, bus.ovf}, 0);
`endif
    @(negedge clk); rst_ = 1'b1;

    for (int i = 0; i < 9; i++)
      run($sformatf("tbl%0d", i), tbl[i].mode, tbl[i].din, tbl[i].shamt, tbl[i].exp, tbl[i].lat, 1'b0);

    // Back-pressure: result held, competing request ignored.
    @(negedge clk);
    bus.in_valid = 1'b1; bus.din = 8'h01; bus.mode = 3'd1; bus.shamt = 3'd2;
    @(posedge clk); #1;
    bus.din = 8'hFF; bus.mode = 3'd1; bus.shamt = 3'd1;
    repeat (2) @(posedge clk);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk($sformatf("bp_ov%0d", c), bus.out_valid, 1);
      chk($sformatf("bp_dout%0d", c), bus.dout, 8'h04);
      chk($sformatf("bp_inrdy%0d", c), bus.in_ready, 0);
    end
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    chk("bp_release", bus.out_valid, 0);
    run("bp_next", 3'd0, 8'h80, 3'd1, 8'h40, 1, 1'b0);

    // Reset in the middle of a long shift.
    @(negedge clk);
    bus.in_valid = 1'b1; bus.din = 8'hA5; bus.mode = 3'd0; bus.shamt = 3'd7;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_ = 1'b0; #1;
    chk("mid_rst_dout", bus.dout, 0);
    chk("mid_rst_ov", bus.out_valid, 0);
    chk("mid_rst_busy", bus.busy, 0);
    chk("mid_rst_inrdy", bus.in_ready, 1);
    @(negedge clk); rst_ = 1'b1;
    repeat (10) @(posedge clk); #1;
    chk("post_rst_ov", bus.out_valid, 0);

    // Randomized requests against the closed-form model.
    for (int r = 0; r < 60; r++) begin
      logic [2:0]    m;
      logic [W-1:0]  d;
      logic [SW-1:0] s;
      m = 3'($urandom); d = W'($urandom); s = SW'($urandom);
      run($sformatf("rnd%0d", r), m, d, s, model(m, d, int'(s)),
          (s != 0 && m < 3'd6) ? int'(s) : 0, 1'b1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
